// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions used by both the encode and decode sides.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   STATE_T   : decoder FSM states
//   SEG_W     : segment bus width (bit6=a .. bit0=g, 1 = lit)
//   DIGIT_W   : hex digit width
//   SEG_0..F  : canonical segment pattern for each digit
package sevenseg_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } STATE_T;

  //                                             abcdefg
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_E = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_F = 7'b1000111;

endpackage

// File: rtl/sevenseg_decoder_4_if.sv
// Segment-bus link between a segment source and the seven-segment decoder.
// Latency: n/a (wires only).
// Backpressure: none; the segment bus is sampled every clock.
//   enable : source -> decoder, freezes FSM/counter/outputs when low
//   seg    : source -> decoder, raw segment pattern
//   value/valid/update/err : decoder -> consumer, recovered digit and strobes
interface sevenseg_decoder_4_if;
  import sevenseg_pkg::*;

  logic               enable;
  logic [SEG_W-1:0]   seg;
  logic [DIGIT_W-1:0] value;
  logic               valid;
  logic               update;
  logic               err;

  // Source / stimulus side.
  modport master (
    output enable,
    output seg,
    input  value,
    input  valid,
    input  update,
    input  err
  );

  // Decoder side.
  modport slave (
    input  enable,
    input  seg,
    output value,
    output valid,
    output update,
    output err
  );

endinterface

// File: rtl/sevenseg_lut.sv
// Combinational segment-pattern to hex-digit lookup (exact match only).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
//   seg_i   : segment pattern, bit6=a .. bit0=g
//   hit_o   : pattern is a recognised digit
//   digit_o : decoded digit, 0 when hit_o is low
// SEVENSEG_HEX_EN defined: A-F are recognised; otherwise only 0-9 are.
module sevenseg_lut
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0]   seg_i,
  output logic               hit_o,
  output logic [DIGIT_W-1:0] digit_o
);

  always_comb begin
    hit_o   = 1'b1;
    digit_o = 4'h0;
    case (seg_i)
      SEG_0:   digit_o = 4'h0;
      SEG_1:   digit_o = 4'h1;
      SEG_2:   digit_o = 4'h2;
      SEG_3:   digit_o = 4'h3;
      SEG_4:   digit_o = 4'h4;
      SEG_5:   digit_o = 4'h5;
      SEG_6:   digit_o = 4'h6;
      SEG_7:   digit_o = 4'h7;
      SEG_8:   digit_o = 4'h8;
      SEG_9:   digit_o = 4'h9;
`ifdef SEVENSEG_HEX_EN
      SEG_A:   digit_o = 4'hA;
      SEG_B:   digit_o = 4'hB;
      SEG_C:   digit_o = 4'hC;
      SEG_D:   digit_o = 4'hD;
      SEG_E:   digit_o = 4'hE;
      SEG_F:   digit_o = 4'hF;
`endif
      // Blank, partial and (decimal build) letter patterns all land here.
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_decoder_4.sv
// Seven-segment receive decoder: debounces the segment bus and recovers the hex digit.
// Latency: outputs change STABLE_CYCLES edges after a new pattern first reaches seg_q.
// Backpressure: none; enable low freezes FSM/counter/outputs, input register keeps sampling.
//   clk    : only clock, rising edge
//   reset  : asynchronous, active-high, clears all state
//   bus    : slave modport (enable, seg in; value, valid, update, err out)
// SEVENSEG_HEX_EN (applied in sevenseg_lut) widens recognition from 0-9 to 0-F.
module sevenseg_decoder_4
  import sevenseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 3  // legal 2..15
) (
  input  logic                  clk,
  input  logic                  reset,
  sevenseg_decoder_4_if.slave   bus
);

  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_PRE  = 4'(STABLE_CYCLES - 1);

  STATE_T             state_q, state_d;
  logic [SEG_W-1:0]   seg_q;
  logic [SEG_W-1:0]   cand_q, cand_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [DIGIT_W-1:0] value_q, value_d;
  logic               valid_q, valid_d;
  logic               update_q, update_d;
  logic               err_q, err_d;

  logic               lut_hit;
  logic [DIGIT_W-1:0] lut_digit;

  // Decoding seg_q is enough: an accept only happens when seg_q == candidate.
  sevenseg_lut u_lut (
    .seg_i   (seg_q),
    .hit_o   (lut_hit),
    .digit_o (lut_digit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      seg_q    <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= bus.seg;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    valid_d  = valid_q;
    // Strobes drop every cycle, so a frozen (enable low) cycle never stretches a pulse.
    update_d = 1'b0;
    err_d    = 1'b0;

    if (bus.enable) begin
      case (state_q)
        EMPTY: begin
          cand_d  = seg_q;
          cnt_d   = 4'd1;
          state_d = TRACK;
        end

        TRACK: begin
          if (seg_q != cand_q) begin
            cand_d = seg_q;
            cnt_d  = 4'd1;
          end else if (cnt_q == CNT_PRE) begin
            // This sample completes the run: accept and park in HOLD.
            cnt_d   = CNT_LAST;
            state_d = HOLD;
            if (lut_hit) begin
              value_d  = lut_digit;
              valid_d  = 1'b1;
              update_d = !valid_q || (lut_digit != value_q);
            end else begin
              err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        HOLD: begin
          // A held pattern is never re-accepted; only a change restarts tracking.
          if (seg_q != cand_q) begin
            cand_d  = seg_q;
            cnt_d   = 4'd1;
            state_d = TRACK;
          end
        end

        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  assign bus.value  = value_q;
  assign bus.valid  = valid_q;
  assign bus.update = update_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sevenseg_decoder_4.sv
// Directed bench for sevenseg_decoder_4 (STABLE_CYCLES = 3).
// Table of held patterns with hand-computed results, then multi-cycle corner sequences.
module tb_sevenseg_decoder_4;
  import sevenseg_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sevenseg_decoder_4_if bus ();

  sevenseg_decoder_4 #(.STABLE_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [6:0] seg;
    int         exp_value;
    int         exp_valid;
    int         exp_update;
    int         exp_err;
  } vec_t;

  vec_t tbl[20];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(input string name, input logic [6:0] seg,
                              input int v, input int vl, input int up, input int er);
    vec_t r;
    r.name = name; r.seg = seg;
    r.exp_value = v; r.exp_valid = vl; r.exp_update = up; r.exp_err = er;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_out(input string name, input int v, input int vl, input int up, input int er);
    chk({name, ".value"},  int'(bus.value),  v);
    chk({name, ".valid"},  int'(bus.valid),  vl);
    chk({name, ".update"}, int'(bus.update), up);
    chk({name, ".err"},    int'(bus.err),    er);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n edges during which no strobe may fire.
  task automatic quiet(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({name, ".upd_quiet"}, int'(bus.update), 0);
      chk({name, ".err_quiet"}, int'(bus.err),    0);
    end
  endtask

  // Drive a pattern and expect its accept on the 4th edge.
  task automatic hold_accept(input string name, input logic [6:0] seg,
                             input int v, input int vl, input int up, input int er);
    bus.seg = seg;
    quiet(name, 3);
    tick();
    chk_out(name, v, vl, up, er);
  endtask

  initial begin
    tbl[0]  = mk("d0",   7'b1111110, 0, 1, 1, 0);
    tbl[1]  = mk("d1",   7'b0110000, 1, 1, 1, 0);
    tbl[2]  = mk("d2",   7'b1101101, 2, 1, 1, 0);
    tbl[3]  = mk("d3",   7'b1111001, 3, 1, 1, 0);
    tbl[4]  = mk("d4",   7'b0110011, 4, 1, 1, 0);
    tbl[5]  = mk("d5",   7'b1011011, 5, 1, 1, 0);
    tbl[6]  = mk("blank",7'b0000000, 5, 1, 0, 1);
    tbl[7]  = mk("d6",   7'b1011111, 6, 1, 1, 0);
    tbl[8]  = mk("d7",   7'b1110000, 7, 1, 1, 0);
    tbl[9]  = mk("d8",   7'b1111111, 8, 1, 1, 0);
    tbl[10] = mk("d9",   7'b1111011, 9, 1, 1, 0);
    tbl[11] = mk("d9rep",7'b1111011, 9, 1, 0, 0);
`ifdef SEVENSEG_HEX_EN
    tbl[12] = mk("dA",   7'b1110111, 10, 1, 1, 0);
    tbl[13] = mk("db",   7'b0011111, 11, 1, 1, 0);
    tbl[14] = mk("dC",   7'b1001110, 12, 1, 1, 0);
    tbl[15] = mk("dd",   7'b0111101, 13, 1, 1, 0);
    tbl[16] = mk("dE",   7'b1001111, 14, 1, 1, 0);
    tbl[17] = mk("dF",   7'b1000111, 15, 1, 1, 0);
    tbl[18] = mk("junk", 7'b0001000, 15, 1, 0, 1);
`else
    tbl[12] = mk("dA",   7'b1110111, 9, 1, 0, 1);
    tbl[13] = mk("db",   7'b0011111, 9, 1, 0, 1);
    tbl[14] = mk("dC",   7'b1001110, 9, 1, 0, 1);
    tbl[15] = mk("dd",   7'b0111101, 9, 1, 0, 1);
    tbl[16] = mk("dE",   7'b1001111, 9, 1, 0, 1);
    tbl[17] = mk("dF",   7'b1000111, 9, 1, 0, 1);
    tbl[18] = mk("junk", 7'b0001000, 9, 1, 0, 1);
`endif
    tbl[19] = mk("d0b",  7'b1111110, 0, 1, 1, 0);

    // Reset state.
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.seg    = 7'b0000000;
    tick();
    tick();
    chk_out("reset", 0, 0, 0, 0);
    reset = 1'b0;

    // Table: each pattern held for four edges, accept lands on the fourth.
    for (int i = 0; i < 20; i++) begin
      bus.seg = tbl[i].seg;
      quiet(tbl[i].name, 3);
      tick();
      chk_out(tbl[i].name, tbl[i].exp_value, tbl[i].exp_valid,
              tbl[i].exp_update, tbl[i].exp_err);
    end

    // Digit 1 for only two samples, then digit 2: only 2 is ever reported.
    reset = 1'b1;
    tick();
    chk_out("rst2", 0, 0, 0, 0);
    reset = 1'b0;
    bus.seg = 7'b0110000;
    quiet("short1", 2);
    bus.seg = 7'b1101101;
    quiet("then2", 3);
    tick();
    chk_out("then2", 2, 1, 1, 0);

    // Blank after digit 5: err, value/valid kept.
    hold_accept("five", 7'b1011011, 5, 1, 1, 0);
    hold_accept("blank5", 7'b0000000, 5, 1, 0, 1);

    // Digit 9, one-sample glitch to 8, back to 9: re-accept without update.
    hold_accept("nine", 7'b1111011, 9, 1, 1, 0);
    bus.seg = 7'b1111111;
    quiet("glitch", 1);
    bus.seg = 7'b1111011;
    quiet("glitch_ret", 4);
    chk_out("glitch_ret", 9, 1, 0, 0);

    // Enable low for 4 cycles while tracking digit 3: accept slips by 4 edges.
    bus.seg = 7'b1111001;
    quiet("en_trk", 2);
    bus.enable = 1'b0;
    quiet("en_low", 4);
    chk_out("en_low", 9, 1, 0, 0);
    bus.enable = 1'b1;
    quiet("en_resume", 1);
    tick();
    chk_out("en_acc", 3, 1, 1, 0);

    // Reset mid-count clears outputs with no clock edge.
    bus.seg = 7'b1110000;
    quiet("pre_rst", 2);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    // Restart from EMPTY: the held 7 is accepted on the fourth edge.
    quiet("restart", 3);
    tick();
    chk_out("restart", 7, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
